// File: rtl/python_pkg.sv
// Shared definitions for the PYTHON sensor trigger path: sync codes and the
// frame-trigger state encoding.
package python_pkg;

    localparam logic [7:0] FS = 8'hAA;
    localparam logic [7:0] FE = 8'hBA;
    localparam logic [7:0] LS = 8'h2A;
    localparam logic [7:0] LE = 8'h4A;
    localparam logic [7:0] WN = 8'h00;
    localparam logic [7:0] IM = 8'h35;
    localparam logic [7:0] BL = 8'h15;
    localparam logic [7:0] CS = 8'h59;
    localparam logic [7:0] TR = 8'hE9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRIG    = 2'd1,
        WAIT_FS = 2'd2,
        WAIT_FE = 2'd3
    } trig_state_t;

    function automatic logic is_active(input trig_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/trig_period_timer.sv
// Free-running period counter; tick is asserted in every cycle the counter
// sits at zero while triggering is enabled.
module trig_period_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                c,
    input  logic                r_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] PZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] PONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] pc_q;
    logic [PERIOD_W-1:0] pc_d;
    logic                run_s;

    // Next count; >= rather than == so a period shrunk mid-count still wraps
    always_comb begin
        run_s = en && (period != PZERO);
        pc_d  = pc_q;
        if (!run_s) begin
            pc_d = PZERO;
        end else if (pc_q >= (period - PONE)) begin
            pc_d = PZERO;
        end else begin
            pc_d = pc_q + PONE;
        end
        tick = run_s && (pc_q == PZERO);
    end

    // Counter register
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            pc_q <= PZERO;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/python_trigger_sequencer.sv
// Frame-trigger controller: issues periodic sensor triggers and follows the
// FS/FE sync stream to confirm, time out, or count skipped frames.
module python_trigger_sequencer
    import python_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int TRIG_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                c,
    input  logic                r_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [TRIG_W-1:0]   trig_len,
    input  logic [PERIOD_W-1:0] timeout,
    input  logic [7:0]          sync,
    output logic                trigger,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    overrun_cnt
);

    localparam logic [PERIOD_W-1:0] PZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] PONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [TRIG_W-1:0]   TZERO = {TRIG_W{1'b0}};
    localparam logic [TRIG_W-1:0]   TONE  = {{(TRIG_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                tick_s;
    logic [7:0]          sync_q;
    trig_state_t         state_q,       state_d;
    logic [TRIG_W-1:0]   trig_cnt_q,    trig_cnt_d;
    logic [PERIOD_W-1:0] to_cnt_q,      to_cnt_d;
    logic [PERIOD_W-1:0] to_lim_q,      to_lim_d;
    logic                trigger_q,     trigger_d;
    logic                busy_q,        busy_d;
    logic                frame_done_q,  frame_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    frame_cnt_q,   frame_cnt_d;
    logic [CNT_W-1:0]    overrun_cnt_q, overrun_cnt_d;
    logic [PERIOD_W-1:0] to_next_s;
    logic                to_hit_s;

    trig_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .c      (c),
        .r_n    (r_n),
        .en     (en),
        .period (period),
        .tick   (tick_s)
    );

    // Next-state logic. The timeout test looks one count ahead so the abort
    // lands exactly timeout cycles after trigger rises.
    always_comb begin
        state_d       = state_q;
        trig_cnt_d    = trig_cnt_q;
        to_cnt_d      = to_cnt_q;
        to_lim_d      = to_lim_q;
        trigger_d     = trigger_q;
        busy_d        = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        to_next_s     = to_cnt_q + PONE;
        to_hit_s      = (to_lim_q != PZERO) && (to_next_s == to_lim_q);

        if (tick_s && is_active(state_q)) begin
            overrun_cnt_d = overrun_cnt_q + CONE;
        end else begin
            overrun_cnt_d = overrun_cnt_q;
        end

        case (state_q)
            IDLE: begin
                trigger_d = 1'b0;
                if (tick_s) begin
                    state_d    = TRIG;
                    trigger_d  = 1'b1;
                    trig_cnt_d = (trig_len == TZERO) ? TZERO : (trig_len - TONE);
                    to_cnt_d   = PZERO;
                    to_lim_d   = timeout;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                to_cnt_d = to_next_s;
                if (to_hit_s) begin
                    state_d       = IDLE;
                    trigger_d     = 1'b0;
                    timeout_err_d = 1'b1;
                end else if (trig_cnt_q == TZERO) begin
                    state_d   = WAIT_FS;
                    trigger_d = 1'b0;
                end else begin
                    trig_cnt_d = trig_cnt_q - TONE;
                end
            end
            WAIT_FS: begin
                to_cnt_d = to_next_s;
                if (to_hit_s) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else if (sync_q == FS) begin
                    state_d = WAIT_FE;
                end else begin
                    state_d = WAIT_FS;
                end
            end
            WAIT_FE: begin
                to_cnt_d = to_next_s;
                // FE beats a timeout that expires in the same cycle
                if (sync_q == FE) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + CONE;
                end else if (to_hit_s) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = WAIT_FE;
                end
            end
            default: begin
                state_d   = IDLE;
                trigger_d = 1'b0;
            end
        endcase

        busy_d = is_active(state_d);
    end

    // State, counters and registered outputs
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            sync_q        <= BL;
            state_q       <= IDLE;
            trig_cnt_q    <= TZERO;
            to_cnt_q      <= PZERO;
            to_lim_q      <= PZERO;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= CZERO;
            overrun_cnt_q <= CZERO;
        end else begin
            sync_q        <= sync;
            state_q       <= state_d;
            trig_cnt_q    <= trig_cnt_d;
            to_cnt_q      <= to_cnt_d;
            to_lim_q      <= to_lim_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign trigger     = trigger_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_python_trigger_sequencer.sv
// Bench for python_trigger_sequencer: a sensor model answers each looped-back
// trigger with FS/FE, and a tick-level frame model predicts every event.
module tb_python_trigger_sequencer;
    import python_pkg::*;

    logic        c = 1'b0;
    logic        r_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] period = 32'd0;
    logic [15:0] trig_len = 16'd0;
    logic [31:0] timeout = 32'd0;
    logic [7:0]  sync = BL;
    logic        trigger, busy, frame_done, timeout_err;
    logic [15:0] frame_cnt, overrun_cnt;

    python_trigger_sequencer #(.PERIOD_W(32), .TRIG_W(16), .CNT_W(16)) dut (
        .c(c), .r_n(r_n), .en(en), .period(period), .trig_len(trig_len),
        .timeout(timeout), .sync(sync), .trigger(trigger), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err),
        .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // Sensor model configuration and observed-event queues
    int fs_d = 20, fe_d = 100;
    bit send_fs = 1'b1;
    int fs_at = -1, fe_at = -1;
    int rise_q[$], width_q[$], done_q[$], to_q[$];
    int bad_to = 0;
    int cur_w = 0;
    logic trig_prev = 1'b0;

    function automatic logic [7:0] pick_filler(input int i);
        case (i)
            0: return BL;
            1: return LS;
            2: return LE;
            3: return IM;
            4: return TR;
            5: return WN;
            default: return CS;
        endcase
    endfunction

    // Monitor and sensor trigger detection, sampled mid-cycle
    always @(negedge c) begin
        if (!r_n) begin
            fs_at = -1; fe_at = -1; trig_prev = 1'b0; cur_w = 0;
        end else begin
            if (trigger && !trig_prev) begin
                rise_q.push_back(cyc);
                fs_at = cyc + fs_d;
                fe_at = cyc + fe_d;
            end
            if (trigger) cur_w++;
            else if (trig_prev) begin width_q.push_back(cur_w); cur_w = 0; end
            if (frame_done) done_q.push_back(cyc);
            if (timeout_err) begin
                to_q.push_back(cyc);
                if (trigger || busy) bad_to++;
            end
            trig_prev = trigger;
        end
    end

    // Sensor sync output
    always @(posedge c) begin
        #1;
        if (send_fs && cyc == fs_at) sync = FS;
        else if (cyc == fe_at) sync = FE;
        else sync = pick_filler($urandom_range(0, 6));
    end

    task automatic wait_until(input int k);
        while (cyc < k) @(posedge c);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge c); #1;
        r_n = 1'b0; en = 1'b0;
        repeat (3) @(posedge c);
        #1;
        r_n = 1'b1;
        rise_q.delete(); width_q.delete(); done_q.delete(); to_q.delete();
        bad_to = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge c);
        #1;
        n_chk++; if (trigger !== 1'b0) $display("FAIL reset_trigger got %b want 0", trigger); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (frame_done !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL reset_pulses got %b%b want 00", frame_done, timeout_err); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
        n_chk++; if (overrun_cnt !== 16'd0) $display("FAIL reset_overrun_cnt got %0d want 0", overrun_cnt); else n_pass++;
        r_n = 1'b1; period = 32'd100; en = 1'b0;
        repeat (30) @(posedge c);
        #1;
        n_chk++; if (rise_q.size() != 0) $display("FAIL disabled_no_trigger got %0d rises want 0", rise_q.size()); else n_pass++;
    endtask

    // Runs nper periods and checks every event against a tick-level model
    task automatic test_frames(input string name, input int p, input int l, input int tmo,
                               input int fsd, input int fed, input bit snd, input int nper);
        int t0, stop, t, r, done, fin, ovr, leff, n;
        int er[$], ed[$], et[$];
        apply_reset();
        period = 32'(p); trig_len = 16'(l); timeout = 32'(tmo);
        fs_d = fsd; fe_d = fed; send_fs = snd;
        en = 1'b1; t0 = cyc;
        stop = t0 + (nper - 1) * p + 1;
        leff = (l == 0) ? 1 : l;
        fin = t0; ovr = 0;
        for (int k = 0; k < nper; k++) begin
            t = t0 + k * p;
            if (t >= fin) begin
                r = t + 1;
                er.push_back(r);
                done = r + fed + 2;
                if (!snd || (tmo != 0 && done > t + 1 + tmo)) begin
                    et.push_back(t + 1 + tmo); fin = t + 1 + tmo;
                end else begin
                    ed.push_back(done); fin = done;
                end
            end else begin
                ovr++;
            end
        end
        wait_until(stop);
        en = 1'b0;
        wait_until(fin + 5);
        n_chk++; if (rise_q.size() != er.size())
            $display("FAIL %s rise_count got %0d want %0d", name, rise_q.size(), er.size()); else n_pass++;
        n = (rise_q.size() < er.size()) ? rise_q.size() : er.size();
        for (int i = 0; i < n; i++) begin
            n_chk++; if (rise_q[i] != er[i])
                $display("FAIL %s rise_cycle[%0d] got %0d want %0d", name, i, rise_q[i] - t0, er[i] - t0); else n_pass++;
        end
        n = (width_q.size() < er.size()) ? width_q.size() : er.size();
        n_chk++; if (width_q.size() != er.size())
            $display("FAIL %s pulse_count got %0d want %0d", name, width_q.size(), er.size()); else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_chk++; if (width_q[i] != leff)
                $display("FAIL %s trig_width[%0d] got %0d want %0d", name, i, width_q[i], leff); else n_pass++;
        end
        n_chk++; if (done_q != ed)
            $display("FAIL %s frame_done_cycles got %p want %p", name, done_q, ed); else n_pass++;
        n_chk++; if (to_q != et)
            $display("FAIL %s timeout_cycles got %p want %p", name, to_q, et); else n_pass++;
        n_chk++; if (frame_cnt !== 16'(ed.size()))
            $display("FAIL %s frame_cnt got %0d want %0d", name, frame_cnt, ed.size()); else n_pass++;
        n_chk++; if (overrun_cnt !== 16'(ovr))
            $display("FAIL %s overrun_cnt got %0d want %0d", name, overrun_cnt, ovr); else n_pass++;
        n_chk++; if (bad_to != 0)
            $display("FAIL %s timeout_outputs got %0d bad cycles want 0", name, bad_to); else n_pass++;
    endtask

    task automatic test_periodic();
        int fsd;
        fsd = $urandom_range(12, 100);
        test_frames("periodic", 1000, 10, 0, fsd, fsd + $urandom_range(2, 400), 1'b1, 5);
        n_chk++; if (frame_cnt !== 16'd5 || overrun_cnt !== 16'd0)
            $display("FAIL periodic_totals got %0d/%0d want 5/0", frame_cnt, overrun_cnt); else n_pass++;
    endtask

    task automatic test_overrun();
        test_frames("overrun", 200, 10, 0, 20, 295, 1'b1, 6);
        n_chk++; if (overrun_cnt !== 16'd3) $display("FAIL overrun_total got %0d want 3", overrun_cnt); else n_pass++;
        if (rise_q.size() >= 2) begin
            n_chk++; if (rise_q[1] - rise_q[0] != 400)
                $display("FAIL overrun_spacing got %0d want 400", rise_q[1] - rise_q[0]); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        test_frames("timeout", 1000, 10, 500, 20, 100, 1'b0, 2);
        n_chk++; if (frame_cnt !== 16'd0) $display("FAIL timeout_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
        if (to_q.size() >= 1 && rise_q.size() >= 1) begin
            n_chk++; if (to_q[0] - (rise_q[0] - 1) != 501)
                $display("FAIL timeout_latency got %0d want 501", to_q[0] - (rise_q[0] - 1)); else n_pass++;
        end
        n_chk++; if (rise_q.size() != 2) $display("FAIL timeout_retrigger got %0d rises want 2", rise_q.size()); else n_pass++;
    endtask

    task automatic test_fe_timeout_tie();
        int tmo;
        tmo = $urandom_range(100, 400);
        test_frames("fe_tie", 2000, 10, tmo, 30, tmo - 2, 1'b1, 1);
        n_chk++; if (frame_cnt !== 16'd1 || to_q.size() != 0)
            $display("FAIL fe_tie_winner got frames=%0d timeouts=%0d want 1/0", frame_cnt, to_q.size()); else n_pass++;
        test_frames("fe_late", 2000, 10, tmo, 30, tmo - 1, 1'b1, 1);
        n_chk++; if (frame_cnt !== 16'd0 || to_q.size() != 1)
            $display("FAIL fe_late_winner got frames=%0d timeouts=%0d want 0/1", frame_cnt, to_q.size()); else n_pass++;
    endtask

    task automatic test_trig_len0();
        test_frames("len0", 50, 0, 0, 5, 12, 1'b1, 4);
        if (width_q.size() >= 1) begin
            n_chk++; if (width_q[0] != 1) $display("FAIL len0_width got %0d want 1", width_q[0]); else n_pass++;
        end
    endtask

    task automatic test_period0();
        apply_reset();
        period = 32'd0; trig_len = 16'd10; en = 1'b1;
        repeat (10000) @(posedge c);
        #1;
        n_chk++; if (rise_q.size() != 0 || busy !== 1'b0)
            $display("FAIL period0 got rises=%0d busy=%b want 0/0", rise_q.size(), busy); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_random();
        int p, l, leff, fsd, fed, tmo;
        for (int it = 0; it < 4; it++) begin
            p = $urandom_range(60, 300);
            l = $urandom_range(0, 12);
            leff = (l == 0) ? 1 : l;
            fsd = leff + 1 + $urandom_range(0, 10);
            fed = fsd + 2 + $urandom_range(0, 2 * p);
            tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(leff + 2, fed + 20);
            test_frames("random", p, l, tmo, fsd, fed, 1'b1, $urandom_range(4, 8));
        end
    endtask

    task automatic test_reset_mid();
        int t0, k;
        apply_reset();
        period = 32'd200; trig_len = 16'd10; timeout = 32'd0;
        fs_d = 20; fe_d = 250; send_fs = 1'b1;
        en = 1'b1; t0 = cyc;
        wait_until(t0 + 441);
        n_chk++; if (frame_cnt !== 16'd1 || overrun_cnt !== 16'd1 || busy !== 1'b1)
            $display("FAIL pre_reset got frames=%0d overruns=%0d busy=%b want 1/1/1", frame_cnt, overrun_cnt, busy); else n_pass++;
        #1; r_n = 1'b0; #1;
        n_chk++; if (busy !== 1'b0 || frame_cnt !== 16'd0 || overrun_cnt !== 16'd0 || frame_done !== 1'b0)
            $display("FAIL async_reset got busy=%b frames=%0d overruns=%0d want 0/0/0", busy, frame_cnt, overrun_cnt); else n_pass++;
        @(posedge c); #1;
        r_n = 1'b1; k = cyc;
        rise_q.delete();
        wait_until(k + 4);
        n_chk++; if (rise_q.size() != 1) $display("FAIL restart_rises got %0d want 1", rise_q.size()); else n_pass++;
        if (rise_q.size() >= 1) begin
            n_chk++; if (rise_q[0] != k + 1) $display("FAIL restart_cycle got %0d want 1", rise_q[0] - k); else n_pass++;
        end
        n_chk++; if (trigger !== 1'b1) $display("FAIL restart_trigger got %b want 1", trigger); else n_pass++;
        #1; r_n = 1'b0; #1;
        n_chk++; if (trigger !== 1'b0) $display("FAIL async_trigger_drop got %b want 0", trigger); else n_pass++;
        @(posedge c); #1;
        r_n = 1'b1; en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_periodic();
        test_overrun();
        test_timeout();
        test_fe_timeout_tie();
        test_trig_len0();
        test_period0();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
